arith_arb: RTL and testbench

ARITH_ARB -- requirements
Module: arith_arb

---
 rtl/arith_arb.sv | 110 +++++++++++
 tb/tb_arith_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/arith_arb.sv
// Two-requester round-robin arbiter sharing one 8-bit add/subtract unit.
// Optional signed saturation; one operation accepted every three cycles.
module arith_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] A0,
  input  logic [7:0] B0,
  input  logic [7:0] A1,
  input  logic [7:0] B1,
  input  logic       sub0,
  input  logic       sub1,
  input  logic       sat_en,
  output logic       done0,
  output logic       done1,
  output logic [7:0] RES,
  output logic       OV,
  output logic       busy
);

  // state | meaning
  // IDLE  | waiting for a request; a grant latches that requester's operands
  // CALC  | latched operands feed the adder; result registered at next edge
  // DONE  | done pulse to the granted requester, then back to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       take;
  logic       finish;
  logic       grant_sel;
  logic       gnt_q;
  logic       last_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       sub_q;
  logic       sat_q;
  logic [7:0] b_eff;
  logic [7:0] sum;
  logic       ov_d;
  logic [7:0] res_d;

  // On a tie the requester that was not served last wins.
  assign grant_sel = (req0 && req1) ? ~last_q : req1;

  assign b_eff = sub_q ? ~b_q : b_q;
  assign sum   = a_q + b_eff + {7'd0, sub_q};
  assign ov_d  = (a_q[7] == b_eff[7]) && (sum[7] != a_q[7]);
  assign res_d = (sat_q && ov_d) ? (a_q[7] ? 8'h80 : 8'h7F) : sum;

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          take    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        finish  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      sub_q   <= 1'b0;
      sat_q   <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      RES     <= 8'h00;
      OV      <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
    end else begin
      state_q <= state_d;
      done0   <= finish && !gnt_q;
      done1   <= finish && gnt_q;
      if (take) begin
        a_q    <= grant_sel ? A1 : A0;
        b_q    <= grant_sel ? B1 : B0;
        sub_q  <= grant_sel ? sub1 : sub0;
        sat_q  <= sat_en;
        gnt_q  <= grant_sel;
        last_q <= grant_sel;
      end
      if (finish) begin
        RES <= res_d;
        OV  <= ov_d;
      end
    end
  end

endmodule

// File: tb/tb_arith_arb.sv
// Scoreboard bench for arith_arb: stimulus predicts grant order and result
// from signed integer arithmetic; a monitor checks every done pulse.
module tb_arith_arb;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] A0, B0, A1, B1;
  logic       sub0, sub1, sat_en;
  logic       done0, done1;
  logic [7:0] RES;
  logic       OV;
  logic       busy;

  arith_arb dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .sub0(sub0), .sub1(sub1), .sat_en(sat_en),
    .done0(done0), .done1(done1), .RES(RES), .OV(OV), .busy(busy)
  );

  typedef struct {
    bit         id;
    logic [7:0] res;
    bit         ov;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         last_srv = 1'b1;
  logic [7:0] last_res = 8'h00;
  bit         last_ov = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [7:0] a, input logic [7:0] b, input bit s,
                                 input bit sat, output logic [7:0] r, output bit ov);
    int sa, sb, x;
    sa = $signed(a);
    sb = $signed(b);
    x  = s ? sa - sb : sa + sb;
    ov = (x > 127) || (x < -128);
    if (ov && sat) r = (x > 0) ? 8'h7F : 8'h80;
    else           r = x[7:0];
  endfunction

  // Raise requests (a pending request keeps its operands), predict, wait for done.
  task automatic issue(input bit r0, input bit r1,
                       input logic [7:0] a0, input logic [7:0] b0,
                       input logic [7:0] a1, input logic [7:0] b1,
                       input bit s0, input bit s1, input bit sat,
                       input bit scramble, input bit drop);
    bit         w;
    int         edges;
    exp_t       e;
    logic [7:0] ea, eb;
    bit         es;
    if (r0 && !req0) begin A0 = a0; B0 = b0; sub0 = s0; end
    if (r1 && !req1) begin A1 = a1; B1 = b1; sub1 = s1; end
    req0   = req0 | r0;
    req1   = req1 | r1;
    sat_en = sat;
    if (!req0 && !req1) return;
    w  = (req0 && req1) ? !last_srv : req1;
    last_srv = w;
    ea = w ? A1 : A0;
    eb = w ? B1 : B0;
    es = w ? sub1 : sub0;
    e.id = w;
    ref_op(ea, eb, es, sat, e.res, e.ov);
    exp_q.push_back(e);
    @(posedge clk); #1;
    chk("busy_after_grant", 32'(busy), 32'd1);
    if (scramble) begin
      if (w) begin A1 = 8'($urandom_range(0,255)); B1 = 8'($urandom_range(0,255)); sub1 = ~sub1; end
      else   begin A0 = 8'($urandom_range(0,255)); B0 = 8'($urandom_range(0,255)); sub0 = ~sub0; end
      sat_en = ~sat_en;
    end
    if (drop) begin
      if (w) req1 = 1'b0; else req0 = 1'b0;
    end
    edges = 1;
    while (edges < 10) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done0 || done1) break;
    end
    chk("done_latency", 32'(edges), 32'd2);
    @(posedge clk); #1;
    if (w) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic idle_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    last_res = 8'h00; last_ov = 1'b0; last_srv = 1'b1;
    #3 rst_n = 1'b1;
  endtask

  task automatic reset_mid_calc();
    A0 = 8'h3C; B0 = 8'h11; sub0 = 1'b0; sat_en = 1'b0; req0 = 1'b1; req1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0 = 1'b0;
    last_res = 8'h00; last_ov = 1'b0; last_srv = 1'b1;
    #2;
    chk("rst_calc_done0", 32'(done0), 32'd0);
    chk("rst_calc_res", 32'(RES), 32'h00);
    chk("rst_calc_ov", 32'(OV), 32'd0);
    chk("rst_calc_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_done0", 32'(done0), 32'd0);
    rst_n = 1'b1;
  endtask

  // Monitor: pops and compares on every done pulse, otherwise RES/OV must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done0 || done1) begin
          chk("done_exclusive", 32'(done0 & done1), 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done done0=%0d done1=%0d t=%0t", done0, done1, $time);
          end else begin
            e = exp_q.pop_front();
            chk("done_id", 32'(done1), 32'(e.id));
            chk("res", 32'(RES), 32'(e.res));
            chk("ov", 32'(OV), 32'(e.ov));
            last_res = e.res;
            last_ov  = e.ov;
          end
        end else begin
          chk("res_hold", 32'(RES), 32'(last_res));
          chk("ov_hold", 32'(OV), 32'(last_ov));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    A0 = 8'h00; B0 = 8'h00; A1 = 8'h00; B1 = 8'h00;
    sub0 = 1'b0; sub1 = 1'b0; sat_en = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_res", 32'(RES), 32'h00);
    chk("reset_ov", 32'(OV), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done0", 32'(done0), 32'd0);
    chk("reset_done1", 32'(done1), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    issue(1, 0, 8'h05, 8'h03, 8'h00, 8'h00, 1, 0, 0, 0, 0);
    issue(0, 1, 8'h00, 8'h00, 8'h50, 8'h40, 0, 0, 0, 0, 0);
    issue(0, 1, 8'h00, 8'h00, 8'h50, 8'h40, 0, 0, 1, 0, 0);
    issue(1, 0, 8'h00, 8'h80, 8'h00, 8'h00, 1, 0, 1, 0, 0);
    issue(1, 0, 8'h80, 8'h01, 8'h00, 8'h00, 1, 0, 1, 0, 0);

    @(posedge clk); #1;
    idle_reset();
    issue(1, 1, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0, 0);
    issue(1, 1, 8'h7F, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    issue(1, 1, 8'h00, 8'h00, 8'h90, 8'h20, 0, 1, 1, 0, 0);
    issue(1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    issue(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);

    reset_mid_calc();
    issue(1, 1, 8'h0A, 8'h14, 8'h64, 8'h01, 1, 0, 0, 0, 0);
    issue(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);

    issue(0, 1, 8'h00, 8'h00, 8'h23, 8'h45, 0, 1, 0, 1, 1);
    repeat (4) begin
      @(negedge clk);
      chk("idle_stays", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
            8'($urandom_range(0,255)), 8'($urandom_range(0,255)),
            8'($urandom_range(0,255)), 8'($urandom_range(0,255)),
            1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
            1'($urandom_range(0,1)), ($urandom_range(0,3) == 0));
    end
    issue(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    issue(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
